// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the scanning serial-ADC sampler.
// Holds FSM encodings, default timing and the mux-select width helper.
package adc_scan_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StFrame,
      StConv,
      StAccum,
      StEmit
   } scan_state_e;

   typedef enum logic [2:0] {
      FrIdle,
      FrSetup,
      FrLow,
      FrHigh,
      FrEnd
   } frame_state_e;

   localparam int unsigned DefDataW    = 8;
   localparam int unsigned DefChannels = 4;
   localparam int unsigned DefSclkHalf = 4096;
   localparam int unsigned DefConvWait = 1024;
   localparam int unsigned DefAvgLog2  = 2;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adc_scan_sampler_if.sv
// Result valid/ready port of the sampler: averaged sample plus its channel.
interface adc_scan_sampler_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CH_W   = 2
);
   logic [DATA_W-1:0] res_data;
   logic [CH_W-1:0]   res_ch;
   logic              res_valid;
   logic              res_ready;

   modport master (output res_data, output res_ch, output res_valid, input res_ready);
   modport slave  (input res_data, input res_ch, input res_valid, output res_ready);
endinterface

// File: rtl/adc_serial_frame.sv
// One TLC549-style read: CS low, setup, DATA_W sclk periods MSB first, CS high.
// data holds the last captured word until the next frame starts.
module adc_serial_frame
   import adc_scan_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SCLK_HALF = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              sdo,
   output logic              cs_n,
   output logic              sclk,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data
);
   localparam int unsigned HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   frame_state_e      st_q, st_d;
   logic [HALF_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              half_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= FrIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         shreg_q <= '0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      shreg_d  = shreg_q;
      half_end = (cnt_q == HALF_W'(SCLK_HALF - 1));
      unique case (st_q)
         FrIdle: begin
            if (start) begin
               st_d   = FrSetup;
               cs_n_d = 1'b0;
               cnt_d  = '0;
               bit_d  = '0;
            end
         end
         FrSetup: begin
            if (half_end) begin
               st_d  = FrLow;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + HALF_W'(1);
            end
         end
         FrLow: begin
            // sdo is captured on the same clock that raises sclk
            if (half_end) begin
               st_d    = FrHigh;
               cnt_d   = '0;
               sclk_d  = 1'b1;
               shreg_d = {shreg_q[DATA_W-2:0], sdo};
            end else begin
               cnt_d = cnt_q + HALF_W'(1);
            end
         end
         FrHigh: begin
            if (half_end) begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  st_d = FrEnd;
               end else begin
                  st_d  = FrLow;
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + HALF_W'(1);
            end
         end
         FrEnd: begin
            cs_n_d = 1'b1;
            st_d   = FrIdle;
         end
         default: st_d = FrIdle;
      endcase
   end

   assign cs_n = cs_n_q;
   assign sclk = sclk_q;
   assign busy = (st_q != FrIdle);
   assign done = (st_q == FrEnd);
   assign data = shreg_q;

endmodule

// File: rtl/adc_scan_sampler.sv
// Scans the enabled mux channels, drops the stale frame after each mux change,
// averages 2^AVG_LOG2 frames and offers the result on a valid/ready port.
module adc_scan_sampler
   import adc_scan_pkg::*;
#(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned CHANNELS  = DefChannels,
   parameter int unsigned SCLK_HALF = DefSclkHalf,
   parameter int unsigned CONV_WAIT = DefConvWait,
   parameter int unsigned AVG_LOG2  = DefAvgLog2,
   localparam int unsigned CH_W     = ch_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [CHANNELS-1:0] ch_mask,
   output logic                adc_cs_n,
   output logic                adc_sclk,
   input  logic                adc_sdo,
   output logic [CH_W-1:0]     mux_sel,
   adc_scan_sampler_if.master  res,
   output logic                overrun,
   input  logic                clr_overrun
);
   localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
   localparam int unsigned CNT_W  = AVG_LOG2 + 1;
   localparam int unsigned WAIT_W = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;

   scan_state_e       state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d, mux_sel_q, mux_sel_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              discard_q, discard_d, captured_q, captured_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic [CH_W-1:0]   res_ch_q, res_ch_d;
   logic              res_valid_q, res_valid_d, overrun_q, overrun_d;
   logic              frame_start, frame_busy, frame_done;
   logic [DATA_W-1:0] frame_data;

   // First set mask bit at or after 'from', wrapping; keeps 'from' if mask is empty.
   function automatic logic [CH_W-1:0] next_set(input logic [CHANNELS-1:0] mask,
                                                input int unsigned from);
      logic [CH_W-1:0] pick;
      logic            found;
      int unsigned     idx;
      pick  = CH_W'(from % CHANNELS);
      found = 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         idx = (from + k) % CHANNELS;
         if (!found && mask[idx]) begin
            found = 1'b1;
            pick  = CH_W'(idx);
         end
      end
      return pick;
   endfunction

   adc_serial_frame #(
      .DATA_W   (DATA_W),
      .SCLK_HALF(SCLK_HALF)
   ) u_frame (
      .clk  (clk),
      .rst_n(rst_n),
      .start(frame_start),
      .sdo  (adc_sdo),
      .cs_n (adc_cs_n),
      .sclk (adc_sclk),
      .busy (frame_busy),
      .done (frame_done),
      .data (frame_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         mux_sel_q   <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         wait_q      <= '0;
         discard_q   <= 1'b0;
         captured_q  <= 1'b0;
         res_data_q  <= '0;
         res_ch_q    <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         mux_sel_q   <= mux_sel_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         discard_q   <= discard_d;
         captured_q  <= captured_d;
         res_data_q  <= res_data_d;
         res_ch_q    <= res_ch_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      mux_sel_d   = mux_sel_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      discard_d   = discard_q;
      captured_d  = captured_q;
      res_data_d  = res_data_q;
      res_ch_d    = res_ch_q;
      res_valid_d = res_valid_q;
      overrun_d   = overrun_q;
      if (res_valid_q && res.res_ready) res_valid_d = 1'b0;
      if (clr_overrun) overrun_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable && |ch_mask) begin
               ptr_d   = next_set(ch_mask, 32'(ptr_q));
               state_d = StSelect;
            end
         end
         StSelect: begin
            mux_sel_d  = ptr_q;
            acc_d      = '0;
            cnt_d      = '0;
            discard_d  = 1'b1;
            captured_d = 1'b0;
            wait_d     = '0;
            state_d    = StConv;
         end
         StFrame: begin
            if (frame_done) begin
               captured_d = 1'b1;
               wait_d     = '0;
               state_d    = StConv;
            end
         end
         StConv: begin
            if (wait_q == WAIT_W'(CONV_WAIT - 1)) state_d = StAccum;
            else wait_d = wait_q + WAIT_W'(1);
         end
         StAccum: begin
            // Right after SELECT nothing has been read yet; the next frame is the stale one.
            if (!enable) begin
               state_d = StIdle;
            end else if (!captured_q) begin
               state_d = StFrame;
            end else if (discard_q) begin
               discard_d = 1'b0;
               state_d   = StFrame;
            end else begin
               acc_d   = acc_q + ACC_W'(frame_data);
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = (cnt_d == CNT_W'(1 << AVG_LOG2)) ? StEmit : StFrame;
            end
         end
         StEmit: begin
            if (!res_valid_q || res.res_ready) begin
               res_data_d  = DATA_W'(acc_q >> AVG_LOG2);
               res_ch_d    = ptr_q;
               res_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
            ptr_d   = next_set(ch_mask, 32'(ptr_q) + 32'd1);
            state_d = (enable && |ch_mask) ? StSelect : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign frame_start   = (state_q == StAccum) && (state_d == StFrame) && !frame_busy;
   assign mux_sel       = mux_sel_q;
   assign overrun       = overrun_q;
   assign res.res_data  = res_data_q;
   assign res.res_ch    = res_ch_q;
   assign res.res_valid = res_valid_q;

endmodule

// File: tb/tb_adc_scan_sampler.sv
// Directed bench: serial ADC model feeding the sampler, scoreboard on the result port.
module tb_adc_scan_sampler;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned CHANNELS  = 2;
   localparam int unsigned SCLK_HALF = 2;
   localparam int unsigned CONV_WAIT = 10;
   localparam int unsigned AVG_LOG2  = 1;

   typedef struct packed {
      logic [7:0] data;
      logic       ch;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable = 1'b0;
   logic [1:0] ch_mask = 2'b00;
   logic       adc_cs_n, adc_sclk, overrun;
   logic       adc_sdo = 1'b0;
   logic       clr_overrun = 1'b0;
   logic [0:0] mux_sel;

   adc_scan_sampler_if #(.DATA_W(8), .CH_W(1)) res_if ();

   adc_scan_sampler #(
      .DATA_W   (DATA_W),
      .CHANNELS (CHANNELS),
      .SCLK_HALF(SCLK_HALF),
      .CONV_WAIT(CONV_WAIT),
      .AVG_LOG2 (AVG_LOG2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .ch_mask    (ch_mask),
      .adc_cs_n   (adc_cs_n),
      .adc_sclk   (adc_sclk),
      .adc_sdo    (adc_sdo),
      .mux_sel    (mux_sel),
      .res        (res_if.master),
      .overrun    (overrun),
      .clr_overrun(clr_overrun)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0, n_fail = 0;
   exp_t       sb[$];
   logic [7:0] frame_q[$];
   logic [7:0] chan_val[2];
   logic [7:0] word = 8'h00;
   int         rises = 0, frames_started = 0, xfer_cnt = 0, valid_pulses = 0, mux_changes = 0;
   logic       frame_mux = 1'b0;
   logic       cs_prev = 1'b1, sclk_prev = 1'b0, valid_prev = 1'b0, have_rise = 1'b0;
   longint     cyc = 0, rise_cyc = 0;
   int         f0, x0, v0, m0;
   exp_t       e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_xfers(input int target, input int budget);
      for (int i = 0; i < budget && xfer_cnt < target; i++) step(1);
      check("xfer_count", xfer_cnt, target);
   endtask

   always @(negedge clk) cyc <= cyc + 1;

   // ADC model: word loads on CS fall, next bit on each sclk fall; also frame timing checks.
   initial begin
      forever begin
         @(adc_cs_n or adc_sclk or rst_n);
         if (!rst_n) begin
            have_rise = 1'b0;
            rises     = 0;
         end else begin
            if (cs_prev && !adc_cs_n) begin
               word = (frame_q.size() != 0) ? frame_q.pop_front() : chan_val[mux_sel];
               adc_sdo = word[7];
               rises = 0;
               frames_started++;
               frame_mux = mux_sel;
               if (have_rise)
                  check("cs_gap", ((cyc - rise_cyc) >= CONV_WAIT) ? CONV_WAIT : 32'(cyc - rise_cyc),
                        CONV_WAIT);
            end else if (!cs_prev && adc_cs_n) begin
               check("sclk_edges", rises, DATA_W);
               have_rise = 1'b1;
               rise_cyc  = cyc;
            end
            if (!adc_cs_n && !sclk_prev && adc_sclk) rises++;
            if (!adc_cs_n && sclk_prev && !adc_sclk) begin
               word = word << 1;
               adc_sdo = word[7];
            end
         end
         cs_prev   = adc_cs_n;
         sclk_prev = adc_sclk;
      end
   end

   initial begin
      forever begin
         @(mux_sel);
         if (rst_n) mux_changes++;
      end
   end

   // Result monitor: a transfer is valid&ready seen mid-cycle, completed on the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && res_if.res_valid && !valid_prev) valid_pulses++;
         valid_prev = res_if.res_valid;
         if (rst_n && res_if.res_valid && res_if.res_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
               n_fail++;
               $error("FAIL xfer_unexpected: observed data %0h, expected no transfer",
                      res_if.res_data);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("res_data", res_if.res_data, e.data);
               check("res_ch", res_if.res_ch, e.ch);
               check("frame_mux", frame_mux, e.ch);
            end
            xfer_cnt++;
         end
      end
   end

   initial begin
      chan_val[0] = 8'h00;
      chan_val[1] = 8'h00;
      res_if.res_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_cs_n", adc_cs_n, 1);
      check("rst_sclk", adc_sclk, 0);
      check("rst_mux_sel", mux_sel, 0);
      check("rst_res_data", res_if.res_data, 0);
      check("rst_res_ch", res_if.res_ch, 0);
      check("rst_res_valid", res_if.res_valid, 0);
      check("rst_overrun", overrun, 0);
      step(3);
      rst_n = 1'b1;
      step(2);

      // Single channel: stale A5 dropped, (10+20)/2
      f0 = frames_started;
      frame_q = '{8'hA5, 8'h10, 8'h20};
      sb.push_back('{data: 8'h18, ch: 1'b0});
      ch_mask = 2'b01;
      res_if.res_ready = 1'b1;
      enable = 1'b1;
      wait_xfers(1, 2000);
      enable = 1'b0;
      step(120);
      check("t1_frames", frames_started - f0, 3);
      check("t1_idle_cs_n", adc_cs_n, 1);

      // Two channels alternating
      f0 = frames_started;
      m0 = mux_changes;
      x0 = xfer_cnt;
      chan_val[0] = 8'h40;
      chan_val[1] = 8'hC0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{data: 8'h40, ch: 1'b0});
         sb.push_back('{data: 8'hC0, ch: 1'b1});
      end
      ch_mask = 2'b11;
      enable = 1'b1;
      wait_xfers(x0 + 4, 4000);
      enable = 1'b0;
      step(120);
      check("t2_mux_toggles", mux_changes - m0, 4);
      check("t2_frames", frames_started - f0, 12);

      // Back-pressure: first result held, second dropped
      x0 = xfer_cnt;
      chan_val[0] = 8'h33;
      ch_mask = 2'b01;
      res_if.res_ready = 1'b0;
      sb.push_back('{data: 8'h33, ch: 1'b0});
      enable = 1'b1;
      for (int i = 0; i < 4000 && !overrun; i++) step(1);
      check("t3_overrun_set", overrun, 1);
      check("t3_held_valid", res_if.res_valid, 1);
      check("t3_held_data", res_if.res_data, 8'h33);
      check("t3_held_ch", res_if.res_ch, 0);
      enable = 1'b0;
      step(120);
      check("t3_overrun_sticky", overrun, 1);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      check("t3_overrun_clr", overrun, 0);
      res_if.res_ready = 1'b1;
      wait_xfers(x0 + 1, 10);
      step(1);
      check("t3_valid_drop", res_if.res_valid, 0);

      // enable dropped in the 4th bit of the first frame
      f0 = frames_started;
      v0 = valid_pulses;
      chan_val[0] = 8'h55;
      enable = 1'b1;
      for (int i = 0; i < 500 && !(adc_cs_n == 1'b0 && rises >= 3); i++) step(1);
      check("t4_mid_frame", rises, 3);
      enable = 1'b0;
      step(150);
      check("t4_frames", frames_started - f0, 1);
      check("t4_no_valid", valid_pulses - v0, 0);
      check("t4_idle_cs_n", adc_cs_n, 1);

      // Full-scale average and truncation
      x0 = xfer_cnt;
      frame_q = '{8'h00, 8'hFF, 8'hFF, 8'h77, 8'h01, 8'h00};
      sb.push_back('{data: 8'hFF, ch: 1'b0});
      sb.push_back('{data: 8'h00, ch: 1'b0});
      enable = 1'b1;
      wait_xfers(x0 + 2, 4000);
      enable = 1'b0;
      step(120);

      // Asynchronous reset with sclk high, result held and overrun set
      chan_val[0] = 8'h21;
      res_if.res_ready = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 4000 && !overrun; i++) step(1);
      check("t6_overrun_set", overrun, 1);
      for (int i = 0; i < 500 && !(adc_sclk == 1'b1 && adc_cs_n == 1'b0); i++) step(1);
      check("t6_sclk_high", adc_sclk, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_cs_n", adc_cs_n, 1);
      check("t6_rst_sclk", adc_sclk, 0);
      check("t6_rst_valid", res_if.res_valid, 0);
      check("t6_rst_overrun", overrun, 0);
      check("t6_rst_res_data", res_if.res_data, 0);
      check("t6_rst_mux_sel", mux_sel, 0);
      enable = 1'b0;
      step(2);
      check("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_scan_sampler.md
Name: adc_scan_sampler

Overview:
- Parametrised successor to the single-channel serial ADC receiver used by the voltmeter top.
- Drives a TLC549-style serial ADC: chip select, serial clock, MSB-first data. Scans up to CHANNELS analog-mux inputs.
- Discards the stale first frame after each mux change, averages 2^AVG_LOG2 conversions per channel, and presents results through a valid/ready port.
- Sits between the ADC pins and the UART sender and display logic.

Parameters:
- DATA_W, 8: ADC sample width in bits.
- CHANNELS, 4: mux channels scanned, 1..16. CH_W = max(1, clog2(CHANNELS)).
- SCLK_HALF, 4096: system clocks per serial-clock half period, ≥2.
- CONV_WAIT, 1024: system clocks with CS high between frames. Covers the ADC conversion time.
- AVG_LOG2, 2: log2 of the number of frames averaged per result, 0..4.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: scanning allowed.
- ch_mask, in, CHANNELS: channels included in the scan. Bit i set means channel i is scanned.
- adc_cs_n, out, 1: ADC chip select, active low.
- adc_sclk, out, 1: ADC serial clock.
- adc_sdo, in, 1: ADC serial data, MSB first.
- mux_sel, out, CH_W: analog mux channel select.
- res_data, out, DATA_W: averaged result.
- res_ch, out, CH_W: channel of res_data.
- res_valid, out, 1: result available.
- res_ready, in, 1: consumer accepts the result.
- overrun, out, 1: sticky flag, set when a result is dropped.
- clr_overrun, in, 1: clears overrun.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=0, mux_sel=0, res_data=0, res_ch=0, res_valid=0, overrun=0. FSM is in IDLE, accumulator is 0.
- IDLE: waits until enable=1 and ch_mask≠0. Then picks the lowest set bit at or above the current pointer (wrapping) and goes to SELECT.
- SELECT: drives mux_sel, clears the accumulator, sets discard=1, then goes to CONV. The initial CONV_WAIT gives mux settle and fresh-conversion time.
- FRAME:
  - adc_cs_n falls, then SCLK_HALF clocks of setup.
  - Then DATA_W sclk periods, each SCLK_HALF low then SCLK_HALF high.
  - adc_sdo is sampled on the system clock where adc_sclk rises, MSB first. Bit 0 is sampled on the last rising edge.
  - adc_sclk returns low, adc_cs_n rises on the next clock, then go to CONV.
- CONV: holds adc_cs_n=1 for CONV_WAIT clocks, then goes to ACCUM.
- ACCUM:
  - If discard=1: clear discard and go to FRAME. This frame holds the conversion started before the mux change.
  - Otherwise add the shift register to the accumulator (width DATA_W+AVG_LOG2, no saturation) and increment the frame count.
  - If count = 2^AVG_LOG2: go to EMIT. Otherwise go to FRAME.
- EMIT: result = accumulator >> AVG_LOG2 (truncating).
  - If res_valid=0, or res_valid=1 with res_ready=1 in this cycle: load res_data and res_ch, res_valid=1.
  - Otherwise drop the result and set overrun=1.
  - Then advance the pointer to the next set ch_mask bit (wrapping) and go to SELECT. If enable=0, go to IDLE instead.
- Handshake: a transfer happens when res_valid and res_ready are both 1 on a clk edge. After a transfer with no simultaneous load, res_valid=0. res_data and res_ch stay stable while res_valid=1 and res_ready=0.
- enable deasserted mid-frame: the current frame and conversion complete, and no partial frame is ever produced. The FSM goes to IDLE at the next ACCUM. The accumulator is discarded.
- ch_mask changes take effect at the next channel selection. If ch_mask=0 at EMIT, go to IDLE.
- CHANNELS=1: mux_sel stays 0. SELECT still runs once per result, including the discard frame.
- overrun: clr_overrun clears it. If clr_overrun and a new drop occur in the same cycle, the set wins.
- Reset mid-frame: all outputs return to their reset values immediately, asynchronously.

Decomposition:
- Package adc_scan_pkg holds:
  - FSM state encoding: IDLE, SELECT, FRAME, CONV, ACCUM, EMIT.
  - A clog2-based CH_W helper.
  - The default timing constants.
- Sub-module adc_serial_frame: CS/SCLK generator and shift register. Interface is start, busy, done and data, parametrised by DATA_W and SCLK_HALF.
- The top level holds the scan FSM, accumulator, discard logic and output register.

Test Plan (bench params: DATA_W=8, CHANNELS=2, SCLK_HALF=2, CONV_WAIT=10, AVG_LOG2=1):
- Reset with rst_n=0 mid-FRAME -> adc_cs_n=1, adc_sclk=0, res_valid=0, overrun=0 in the same cycle, with no clk edge needed.
- ch_mask=2'b01, ADC model returns 0xA5 then 0x10, 0x20 -> 0xA5 is discarded; res_data=0x18, res_ch=0. Exactly 8 sclk rising edges per frame; CS-high gap of 10 clocks checked.
- ch_mask=2'b11, model returns ch0=0x40, ch1=0xC0 (constant), res_ready=1 -> results alternate ch0=0x40, ch1=0xC0. mux_sel toggles at each SELECT.
- res_ready=0 for two full results -> first result held unchanged, second dropped, overrun=1. clr_overrun=1 -> overrun=0.
- enable dropped during the 4th bit of a frame -> that frame completes (8 sclk edges), then IDLE with adc_cs_n=1 and no res_valid pulse.
- Model returns 0xFF, 0xFF after discard -> res_data=0xFF with no accumulator wrap. Then 0x01, 0x00 -> res_data=0x00 (truncation).
